// File: rtl/neuro_cfg_loader_pkg.sv
// neuro_cfg_pkg: loader state encoding and neuron configuration field widths
package neuro_cfg_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, PUSH, DONE} state_t;
   localparam int W_WEIGHT = 3;
   localparam int W_TSEL = 3;
   localparam int W_U = 5;
   localparam int BITS_PER_NEURON = 3 * W_WEIGHT + W_TSEL + W_U;
endpackage

// File: rtl/neuro_cfg_loader_if.sv
// neuro_cfg_loader_if: byte streams, control and bitstream chain pins of the loader
interface neuro_cfg_loader_if;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       conf_en;
   logic       bs_drive;
   logic       bs_ret;
   logic       busy;
   logic       done;
   modport master (
      output start, in_data, in_valid, out_ready, bs_ret,
      input  in_ready, out_data, out_valid, conf_en, bs_drive, busy, done
   );
   modport slave (
      input  start, in_data, in_valid, out_ready, bs_ret,
      output in_ready, out_data, out_valid, conf_en, bs_drive, busy, done
   );
endinterface

// File: rtl/neuro_cfg_loader_serdes.sv
// neuro_cfg_serdes: tx byte shifted out MSB-first while the chain tail is captured LSB-in
module neuro_cfg_serdes (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic       i_shift,
   input  logic [7:0] i_din,
   input  logic       i_ser,
   output logic       o_ser,
   output logic [7:0] o_rx
);
   logic [7:0] r_tx;
   logic [7:0] r_rx;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx <= '0;
         r_rx <= '0;
      end else if (i_load) begin
         r_tx <= i_din;
         r_rx <= '0;
      end else if (i_shift) begin
         r_tx <= {r_tx[6:0], 1'b0};
         r_rx <= {r_rx[6:0], i_ser};
      end
   end
   assign o_ser = r_tx[7];
   assign o_rx = r_rx;
endmodule

// File: rtl/neuro_cfg_loader.sv
// neuro_cfg_loader: streams config bytes into the neuron bitstream chain and returns the displaced bits
module neuro_cfg_loader #(
   parameter int N_NEURONS = 1,
   parameter int BITS_PER_NEURON = neuro_cfg_pkg::BITS_PER_NEURON
) (
   input logic clk,
   input logic nn_reset,
   neuro_cfg_loader_if.slave bus
);
   import neuro_cfg_pkg::*;
   localparam int CHAIN_LEN = N_NEURONS * BITS_PER_NEURON;
   localparam int CW = $clog2(CHAIN_LEN + 1);
   state_t r_state, w_next;
   logic [CW-1:0] r_bit_cnt;
   logic [2:0] r_byte_cnt;
   logic r_in_ready, r_out_valid, r_conf_en, r_busy, r_done;
   logic w_load, w_last, w_tx_msb;
   logic [7:0] w_rx;
   logic [2:0] w_pad;
   assign w_load = r_in_ready & bus.in_valid;
   assign w_last = r_byte_cnt == 3'd7 || r_bit_cnt == CW'(CHAIN_LEN - 1);
   // a partial final byte holds its bits at the bottom; shift them up to left-align
   assign w_pad = 3'(-r_byte_cnt);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? FETCH : IDLE;
         FETCH:   w_next = bus.in_valid ? SHIFT : FETCH;
         SHIFT:   w_next = w_last ? PUSH : SHIFT;
         PUSH:    w_next = !bus.out_ready ? PUSH : r_bit_cnt == CW'(CHAIN_LEN) ? DONE : FETCH;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (nn_reset) begin
         r_state <= IDLE;
         r_bit_cnt <= '0;
         r_byte_cnt <= '0;
         r_in_ready <= 1'b0;
         r_out_valid <= 1'b0;
         r_conf_en <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_state <= w_next;
         r_in_ready <= w_next == FETCH;
         r_out_valid <= w_next == PUSH;
         r_conf_en <= w_next == SHIFT;
         r_busy <= w_next inside {FETCH, SHIFT, PUSH};
         r_done <= w_next == DONE;
         r_bit_cnt <= r_state == IDLE ? '0 : r_bit_cnt + CW'(r_conf_en);
         r_byte_cnt <= w_load ? '0 : r_byte_cnt + 3'(r_conf_en);
      end
   end
   neuro_cfg_serdes u_serdes (
      .clk(clk),
      .rst(nn_reset),
      .i_load(w_load),
      .i_shift(r_conf_en),
      .i_din(bus.in_data),
      .i_ser(bus.bs_ret),
      .o_ser(w_tx_msb),
      .o_rx(w_rx)
   );
   assign bus.in_ready = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data = w_rx << w_pad;
   assign bus.conf_en = r_conf_en;
   assign bus.bs_drive = w_tx_msb & r_conf_en;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule

// File: doc/neuro_cfg_loader.md
Name: neuro_cfg_loader

Overview:
- Drives the neuron array's configuration bitstream chain: bs_in/conf_en into the chain, bs_out back out of it.
- Accepts configuration bytes over a valid/ready stream and serialises them MSB-first into the chain while conf_en is high.
- Simultaneously captures the bits leaving the chain tail and returns them as a byte stream, so one load doubles as a readback of the previous configuration.
- Sits between the top-level pin interface and the neuron array.

Parameters:
- N_NEURONS, 1, number of neurons daisy-chained on the bitstream.
- BITS_PER_NEURON, 17, config bits per neuron: wA 3, wB 3, wC 3, tSel 3, U 5.
- CHAIN_LEN (localparam), N_NEURONS*BITS_PER_NEURON, total chain bits.
- NBYTES (localparam), ceil(CHAIN_LEN/8), bytes consumed and produced per load.

Ports:
- clk  in  1  clock.
- nn_reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a load; ignored while busy.
- in_data  in  8  config byte, MSB shifted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid&&in_ready at posedge.
- out_data  out  8  readback byte, MSB = first bit out of chain tail.
- out_valid  out  1  out_data valid; held until accepted.
- out_ready  in  1  consumer ready.
- conf_en  out  1  registered; chain shifts one bit at every posedge where conf_en=1.
- bs_drive  out  1  registered; feeds chain bs_in.
- bs_ret  in  1  chain tail bs_out.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at end of load.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (nn_reset).
- Reset values: state IDLE; in_ready, out_valid, conf_en, bs_drive, busy, done all 0; out_data 0; bit and byte counters 0.
- States: IDLE, FETCH, SHIFT, PUSH, DONE.
  - IDLE: start=1 -> FETCH.
  - FETCH: in_ready=1; on handshake, latch the byte and go to SHIFT.
  - SHIFT: conf_en=1; bs_drive = current MSB. At each posedge with conf_en=1, sample bs_ret into the readback register (LSB in, shift left), increment bit_cnt, and shift the tx byte left.
  - After 8 bits, or on the last chain bit, -> PUSH.
  - PUSH: out_valid=1 until out_ready. Then: if total bits = CHAIN_LEN -> DONE, else -> FETCH.
  - DONE: done=1 for one cycle -> IDLE.
- conf_en is low in every state except SHIFT. Stalls on in_valid=0 or out_ready=0 therefore freeze the chain.
- Exactly CHAIN_LEN posedges with conf_en=1 per load, regardless of stalls.
- Last partial byte (r = CHAIN_LEN mod 8, r≠0):
  - Only in_data[7:8-r] is shifted; the low bits are discarded.
  - The readback byte is left-aligned with low 8-r bits zero.
- bs_ret sampling: sample on the same edge at which the chain shifts, i.e. the pre-shift tail bit. This is the oldest bit, so the first readback bit is the first bit loaded by the previous load.
- Latency: start to first conf_en=1 is 2 cycles (start->FETCH, handshake->SHIFT) when in_valid is already high.
- Boundaries:
  - start while busy: ignored.
  - in_valid high outside FETCH: not accepted (in_ready=0).
  - out_ready high with out_valid low: no effect.
  - nn_reset mid-load: immediate return to reset values next edge; chain contents are undefined and software must reload; no done pulse.
  - Simultaneous start and nn_reset: reset wins.
- Counters: bit_cnt width clog2(CHAIN_LEN+1); byte-local count 3 bits; no wrap beyond CHAIN_LEN.

Decomposition:
- Package neuro_cfg_pkg: state enum (IDLE, FETCH, SHIFT, PUSH, DONE); BITS_PER_NEURON=17; per-field widths W_WEIGHT=3, W_TSEL=3, W_U=5.
- Sub-module neuro_cfg_serdes: 8-bit tx shift register plus 8-bit rx capture register with shared shift enable and load/clear. The FSM and counters stay in the top.

Test Plan:
- Bench setup: N_NEURONS=1, chain behavioural model preloaded with 0. Load A5,3C,80 -> readback 00,00,00; conf_en high exactly 17 edges; bs_drive sequence 1010_0101_0011_1100_1; done pulses once.
- Second load FF,FF,FF -> readback A5,3C,80 (last byte low 7 bits zero); chain then holds 17 ones.
- out_ready held 0 for 5 cycles after the first readback byte -> conf_en=0 and chain frozen during the stall; final readback is unchanged from the no-stall case.
- in_valid drops for 3 cycles between bytes 1 and 2 -> no extra shifts; total conf_en edges is still 17.
- nn_reset asserted after 9 shifts -> next cycle all outputs 0, state IDLE, no done; a new start performs a full 17-bit load.
- start pulsed mid-load -> ignored; exactly one done; N_NEURONS=3 variant: 51 bits, 7 bytes each way, last byte uses 3 bits.
